// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: latency classes,
// the class-to-latency mapping and the countdown counter width.
package hazard_pkg;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MD   = 2'd2
    } lat_class_e;

    // Counters must hold the longest latency, which is the MUL/DIV latency.
    function automatic int unsigned cnt_width(input int unsigned md_lat);
        return $clog2(md_lat + 1);
    endfunction

    // Cycles after issue until the result can be forwarded; encoding 2'b11 behaves as ALU.
    function automatic int unsigned lat(input logic [1:0] cls,
                                        input int unsigned alu_lat,
                                        input int unsigned load_lat,
                                        input int unsigned md_lat);
        case (cls)
            LAT_LOAD: return load_lat;
            LAT_MD:   return md_lat;
            default:  return alu_lat;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_cnt_array.sv
// Per-register countdown counters: three combinational read ports (rs, rt, dest)
// and one load port. Register 0 is never tracked and always reads zero.
module hazard_cnt_array #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  rs_addr,
    input  logic [RA_W-1:0]  rt_addr,
    input  logic [RA_W-1:0]  dest_addr,
    output logic [CNT_W-1:0] rs_cnt,
    output logic [CNT_W-1:0] rt_cnt,
    output logic [CNT_W-1:0] dest_cnt,
    input  logic             load_en,
    input  logic [RA_W-1:0]  load_addr,
    input  logic [CNT_W-1:0] load_val
);
    import hazard_pkg::*;

    logic [CNT_W-1:0] cnt [NREGS];

    function automatic logic [CNT_W-1:0] rd(input logic [RA_W-1:0] a);
        if (a == '0 || 32'(a) >= NREGS)
            return '0;
        return cnt[a];
    endfunction

    assign rs_cnt   = rd(rs_addr);
    assign rt_cnt   = rd(rt_addr);
    assign dest_cnt = rd(dest_addr);

    // Count every pending entry down by one; a load in the same cycle overrides the decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++)
                cnt[RA_W'(i)] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (i == 0)
                    cnt[RA_W'(i)] <= '0;
                else if (cnt[RA_W'(i)] != '0)
                    cnt[RA_W'(i)] <= cnt[RA_W'(i)] - 1'b1;
            end
            if (load_en && load_addr != '0 && 32'(load_addr) < NREGS)
                cnt[load_addr] <= load_val;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard controller: RAW (incl. branch-in-ID), WAW and multi-cycle
// structural hazards from a per-register countdown scoreboard, plus a
// saturating stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MD_LAT   = 8,
    parameter int          BR_EXTRA = 1,
    parameter int unsigned PERF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [RA_W-1:0]   id_rs,
    input  logic [RA_W-1:0]   id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              id_regwrite,
    input  logic [RA_W-1:0]   id_dest,
    input  logic [1:0]        id_lat_class,
    input  logic              pipe_flush,
    output logic              stall,
    output logic              flush_idex,
    output logic              id_issue,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cycles
);
    import hazard_pkg::*;

    localparam int unsigned CNT_W = cnt_width(MD_LAT);
    // An EX consumer can take a result once cnt <= 1; a branch in ID needs BR_EXTRA more cycles.
    localparam logic [CNT_W-1:0] RAW_LIMIT = CNT_W'(1);
    localparam logic [CNT_W-1:0] BR_LIMIT  = CNT_W'((BR_EXTRA >= 1) ? 0 : 1 - BR_EXTRA);

    logic [CNT_W-1:0] rs_cnt, rt_cnt, dest_cnt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] issue_lat;
    logic [CNT_W-1:0] src_limit;
    logic             raw_rs, raw_rt, waw, structural;
    logic             load_en;

    hazard_cnt_array #(
        .NREGS (NREGS),
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .rs_addr   (id_rs),
        .rt_addr   (id_rt),
        .dest_addr (id_dest),
        .rs_cnt    (rs_cnt),
        .rt_cnt    (rt_cnt),
        .dest_cnt  (dest_cnt),
        .load_en   (load_en),
        .load_addr (id_dest),
        .load_val  (issue_lat)
    );

    // Hazard detection and pipeline control for the instruction currently in ID.
    always_comb begin
        issue_lat  = CNT_W'(lat(id_lat_class, ALU_LAT, LOAD_LAT, MD_LAT));
        src_limit  = id_branch ? BR_LIMIT : RAW_LIMIT;
        raw_rs     = id_uses_rs && id_rs != '0 && rs_cnt > src_limit;
        raw_rt     = id_uses_rt && id_rt != '0 && rt_cnt > src_limit;
        // Keeps writebacks in order: a faster producer must not overtake a pending slower one.
        waw        = id_regwrite && id_dest != '0 && dest_cnt > issue_lat;
        structural = id_lat_class == LAT_MD && md_cnt != '0;
        stall      = !reset && id_valid && !pipe_flush && (raw_rs || raw_rt || waw || structural);
        flush_idex = !reset && (stall || pipe_flush);
        id_issue   = !reset && id_valid && !stall && !pipe_flush;
        load_en    = id_issue && id_regwrite && id_dest != '0;
    end

    assign md_busy = md_cnt != '0;

    // Multi-cycle unit occupancy and saturating stall-cycle count.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            if (id_issue && id_lat_class == LAT_MD)
                md_cnt <= CNT_W'(MD_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - 1'b1;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed pipeline scenarios
// plus randomized instruction streams against a ready-time reference model.
module tb_hazard_scoreboard_unit;

    typedef struct packed {
        logic       valid;
        logic [1:0] cls;
        logic       rw;
        logic [4:0] dest;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       br;
    } ins_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, id_branch = 1'b0, id_regwrite = 1'b0;
    logic [1:0]  id_lat_class = '0;
    logic        pipe_flush = 1'b0;
    logic        stall, flush_idex, id_issue, md_busy;
    logic [15:0] stall_cycles;

    int checks = 0;
    int passes = 0;

    // Reference model: absolute cycle at which each register's result stops blocking.
    longint      avail [32];
    longint      md_free = 0;
    longint      now = 0;
    int unsigned m_sc = 0;

    hazard_scoreboard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_branch    (id_branch),
        .id_regwrite  (id_regwrite),
        .id_dest      (id_dest),
        .id_lat_class (id_lat_class),
        .pipe_flush   (pipe_flush),
        .stall        (stall),
        .flush_idex   (flush_idex),
        .id_issue     (id_issue),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic longint latc(input logic [1:0] c);
        return (c == 2'd1) ? 2 : (c == 2'd2) ? 8 : 1;
    endfunction

    function automatic longint rem(input logic [4:0] r);
        if (r == 0) return 0;
        return (avail[r] > now) ? avail[r] - now : 0;
    endfunction

    function automatic bit m_stall();
        longint lim;
        bit h;
        if (reset || !id_valid || pipe_flush) return 0;
        lim = id_branch ? 0 : 1;
        h = 0;
        if (id_uses_rs && rem(id_rs) > lim) h = 1;
        if (id_uses_rt && rem(id_rt) > lim) h = 1;
        if (id_regwrite && id_dest != 0 && rem(id_dest) > latc(id_lat_class)) h = 1;
        if (id_lat_class == 2'd2 && md_free > now) h = 1;
        return h;
    endfunction

    function automatic bit m_flush();
        return !reset && (m_stall() || pipe_flush);
    endfunction

    function automatic bit m_issue();
        return !reset && id_valid && !pipe_flush && !m_stall();
    endfunction

    function automatic bit m_busy();
        return md_free > now;
    endfunction

    function automatic ins_t op(input logic [1:0] cls, input logic rw, input logic [4:0] dest,
                                input logic urs, input logic [4:0] rs,
                                input logic urt, input logic [4:0] rt, input logic br);
        ins_t i;
        i.valid = 1'b1; i.cls = cls; i.rw = rw; i.dest = dest;
        i.urs = urs; i.rs = rs; i.urt = urt; i.rt = rt; i.br = br;
        return i;
    endfunction

    task automatic drive(input ins_t i, input logic fl);
        id_valid = i.valid; id_lat_class = i.cls; id_regwrite = i.rw; id_dest = i.dest;
        id_uses_rs = i.urs; id_rs = i.rs; id_uses_rt = i.urt; id_rt = i.rt;
        id_branch = i.br; pipe_flush = fl;
    endtask

    task automatic idle();
        drive('0, 1'b0);
    endtask

    // Advance one clock, updating the model from the inputs that were held over the edge.
    task automatic tick();
        bit s, is, r;
        s = m_stall(); is = m_issue(); r = reset;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 32; k++) avail[k] = 0;
            md_free = 0;
            m_sc = 0;
        end else begin
            if (is && id_regwrite && id_dest != 0) avail[id_dest] = now + 1 + latc(id_lat_class);
            if (is && id_lat_class == 2'd2) md_free = now + 1 + 8;
            if (s && m_sc != 65535) m_sc++;
        end
        now++;
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Hold an instruction in ID until the DUT issues it; reports stall/flush cycles seen.
    task automatic run_instr(input ins_t i, output int stalls, output int flushes);
        stalls = 0; flushes = 0;
        drive(i, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (id_issue === 1'b1) begin
                tick();
                return;
            end
            if (stall === 1'b1) stalls++;
            if (flush_idex === 1'b1) flushes++;
            tick();
        end
        stalls = 99;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(op(2'd2, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1), 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else passes++;
        checks++; if (flush_idex !== 1'b0) $display("FAIL reset_flush: got %b expected 0", flush_idex); else passes++;
        checks++; if (id_issue !== 1'b0) $display("FAIL reset_issue: got %b expected 0", id_issue); else passes++;
        tick();
        idle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (md_busy !== 1'b0) $display("FAIL reset_md_busy: got %b expected 0", md_busy); else passes++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall_cycles: got %0d expected 0", stall_cycles); else passes++;
        tick();
    endtask

    task automatic test_load_use();
        int s, f;
        do_reset();
        run_instr(op(2'd1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        run_instr(op(2'd0, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b0), s, f);
        idle();
        checks++; if (s != 1) $display("FAIL load_use_stalls: got %0d expected 1", s); else passes++;
        checks++; if (f != 1) $display("FAIL load_use_flushes: got %0d expected 1", f); else passes++;
        checks++; if (stall_cycles !== 16'd1) $display("FAIL load_use_count: got %0d expected 1", stall_cycles); else passes++;
    endtask

    task automatic test_back_to_back();
        int s, f, s2;
        do_reset();
        run_instr(op(2'd0, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd7, 1'b0), s, f);
        run_instr(op(2'd0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd1, 1'b0), s, f);
        run_instr(op(2'd0, 1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd2, 1'b0), s2, f);
        idle();
        checks++; if (s != 0) $display("FAIL b2b_alu_stalls: got %0d expected 0", s); else passes++;
        checks++; if (s2 != 0) $display("FAIL b2b_chain_stalls: got %0d expected 0", s2); else passes++;
    endtask

    task automatic test_md();
        int s, f;
        do_reset();
        run_instr(op(2'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        checks++; if (md_busy !== 1'b1) $display("FAIL md_busy_after_issue: got %b expected 1", md_busy); else passes++;
        run_instr(op(2'd0, 1'b1, 5'd9, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0), s, f);
        checks++; if (s != 7) $display("FAIL md_consumer_stalls: got %0d expected 7", s); else passes++;
        do_reset();
        run_instr(op(2'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        run_instr(op(2'd2, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        idle();
        checks++; if (s != 8) $display("FAIL md_structural_stalls: got %0d expected 8", s); else passes++;
        checks++; if (stall_cycles !== 16'd8) $display("FAIL md_structural_count: got %0d expected 8", stall_cycles); else passes++;
    endtask

    task automatic test_branch();
        int s, f;
        do_reset();
        run_instr(op(2'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        run_instr(op(2'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b1), s, f);
        checks++; if (s != 1) $display("FAIL branch_after_alu: got %0d expected 1", s); else passes++;
        do_reset();
        run_instr(op(2'd1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        run_instr(op(2'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd0, 1'b1), s, f);
        idle();
        checks++; if (s != 2) $display("FAIL branch_after_load: got %0d expected 2", s); else passes++;
    endtask

    task automatic test_waw_zero();
        int s, f, s2, s3;
        do_reset();
        run_instr(op(2'd2, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        run_instr(op(2'd0, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        checks++; if (s != 7) $display("FAIL waw_stalls: got %0d expected 7", s); else passes++;
        do_reset();
        run_instr(op(2'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        run_instr(op(2'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0), s2, f);
        run_instr(op(2'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1), s3, f);
        idle();
        checks++; if (s2 != 0) $display("FAIL zero_reg_alu: got %0d expected 0", s2); else passes++;
        checks++; if (s3 != 0) $display("FAIL zero_reg_branch: got %0d expected 0", s3); else passes++;
    endtask

    task automatic test_reset_mid_stall();
        int s, f;
        do_reset();
        run_instr(op(2'd2, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        drive(op(2'd2, 1'b1, 5'd11, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0), 1'b0);
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        checks++; if (stall !== 1'b1) $display("FAIL mid_stall_active: got %b expected 1", stall); else passes++;
        reset = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) $display("FAIL mid_stall_forced: got %b expected 0", stall); else passes++;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (stall !== 1'b0) $display("FAIL post_reset_stall: got %b expected 0", stall); else passes++;
        checks++; if (md_busy !== 1'b0) $display("FAIL post_reset_md_busy: got %b expected 0", md_busy); else passes++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL post_reset_count: got %0d expected 0", stall_cycles); else passes++;
        checks++; if (id_issue !== 1'b1) $display("FAIL post_reset_issue: got %b expected 1", id_issue); else passes++;
        tick();
        idle();
    endtask

    task automatic test_pipe_flush();
        int s, f;
        do_reset();
        run_instr(op(2'd1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), s, f);
        drive(op(2'd2, 1'b1, 5'd7, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0), 1'b1);
        @(negedge clk);
        checks++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall); else passes++;
        checks++; if (flush_idex !== 1'b1) $display("FAIL flush_flush_idex: got %b expected 1", flush_idex); else passes++;
        checks++; if (id_issue !== 1'b0) $display("FAIL flush_issue: got %b expected 0", id_issue); else passes++;
        tick();
        drive(op(2'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd2, 1'b1), 1'b0);
        @(negedge clk);
        checks++; if (stall !== 1'b1) $display("FAIL flush_keeps_producer: got %b expected 1", stall); else passes++;
        checks++; if (md_busy !== 1'b0) $display("FAIL flush_md_busy: got %b expected 0", md_busy); else passes++;
        tick();
        @(negedge clk);
        checks++; if (stall !== 1'b0) $display("FAIL flush_no_track: got %b expected 0", stall); else passes++;
        tick();
        idle();
    endtask

    task automatic test_random();
        ins_t i;
        logic fl;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            i.valid = ($urandom_range(0, 99) < 85);
            i.cls   = ($urandom_range(0, 7) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
            if (i.cls == 2'd2 && $urandom_range(0, 1) == 0) i.cls = 2'd0;
            i.rw    = 1'($urandom_range(0, 1));
            i.dest  = 5'($urandom_range(0, 7));
            i.urs   = 1'($urandom_range(0, 1));
            i.rs    = 5'($urandom_range(0, 7));
            i.urt   = 1'($urandom_range(0, 1));
            i.rt    = 5'($urandom_range(0, 7));
            i.br    = ($urandom_range(0, 3) == 0);
            fl      = ($urandom_range(0, 9) == 0);
            drive(i, fl);
            reset = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            checks++; if (stall !== m_stall()) $display("FAIL rnd_stall n=%0d: got %b expected %b", n, stall, m_stall()); else passes++;
            checks++; if (flush_idex !== m_flush()) $display("FAIL rnd_flush n=%0d: got %b expected %b", n, flush_idex, m_flush()); else passes++;
            checks++; if (id_issue !== m_issue()) $display("FAIL rnd_issue n=%0d: got %b expected %b", n, id_issue, m_issue()); else passes++;
            checks++; if (md_busy !== m_busy()) $display("FAIL rnd_md_busy n=%0d: got %b expected %b", n, md_busy, m_busy()); else passes++;
            checks++; if (stall_cycles !== 16'(m_sc)) $display("FAIL rnd_count n=%0d: got %0d expected %0d", n, stall_cycles, m_sc); else passes++;
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        for (int k = 0; k < 32; k++) avail[k] = 0;
        #1;
        test_reset();
        test_load_use();
        test_back_to_back();
        test_md();
        test_branch();
        test_waw_zero();
        test_reset_mid_stall();
        test_pipe_flush();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
